// File: rtl/multicycle_sequencer.sv
// Main control FSM of the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing,
// strobe generation, retired-instruction counting and sticky halt on illegal or bus timeout.
module multicycle_sequencer #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_en,
    input  logic             load,
    input  logic             store,
    input  logic             Jal,
    input  logic             Jalr,
    input  logic             branch_on,
    input  logic             branch_result,
    input  logic             illegal,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             reg_write_en,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             halt,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam int unsigned     TO_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             load_q, load_d;
    logic             store_q, store_d;
    logic             jal_q, jal_d;
    logic             jalr_q, jalr_d;
    logic             branch_q, branch_d;
    logic             taken_q, taken_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            load_q    <= 1'b0;
            store_q   <= 1'b0;
            jal_q     <= 1'b0;
            jalr_q    <= 1'b0;
            branch_q  <= 1'b0;
            taken_q   <= 1'b0;
            tcnt_q    <= '0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            store_q   <= store_d;
            jal_q     <= jal_d;
            jalr_q    <= jalr_d;
            branch_q  <= branch_d;
            taken_q   <= taken_d;
            tcnt_q    <= tcnt_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        store_d   = store_q;
        jal_d     = jal_q;
        jalr_d    = jalr_q;
        branch_d  = branch_q;
        taken_d   = taken_q;
        tcnt_d    = tcnt_q;
        bus_err_d = bus_err_q;
        instret_d = instret_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                load_d   = load;
                store_d  = store;
                jal_d    = Jal;
                jalr_d   = Jalr;
                branch_d = branch_on;
                taken_d  = branch_result;
                if (illegal || (load && store)) state_d = S_HALT;
                else                            state_d = S_EXEC;
            end
            S_EXEC: begin
                tcnt_d  = '0;
                state_d = (load_q || store_q) ? S_MEM : S_WB;
            end
            S_MEM: begin
                // An ack arriving on the final permitted cycle still completes the access.
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (tcnt_q == TO_LAST) begin
                    state_d   = S_HALT;
                    bus_err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            S_WB: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write_en = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 2'b00;
        halt         = 1'b0;
        case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = store_q;
            end
            S_WB: begin
                pc_en        = 1'b1;
                reg_write_en = ~store_q & ~branch_q;
                if (jalr_q)                        pc_sel = 2'b10;
                else if (jal_q || (branch_q && taken_q)) pc_sel = 2'b01;
                else                               pc_sel = 2'b00;
            end
            S_HALT:  halt = 1'b1;
            default: ;
        endcase
    end

    assign ir_en   = (state_q == S_FETCH) & imem_ack;
    assign bus_err = bus_err_q;
    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst, imem_ack, load, store, Jal, Jalr, branch_on, branch_result, illegal, dmem_ack;
    logic       imem_req, ir_en, dmem_req, dmem_we, reg_write_en, pc_en, halt, bus_err;
    logic [1:0] pc_sel;
    logic [3:0] instret;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(4), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_en(ir_en),
        .load(load), .store(store), .Jal(Jal), .Jalr(Jalr),
        .branch_on(branch_on), .branch_result(branch_result), .illegal(illegal),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .reg_write_en(reg_write_en), .pc_en(pc_en), .pc_sel(pc_sel),
        .halt(halt), .bus_err(bus_err), .instret(instret), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fetch_to_exec(input logic ld, input logic st, input logic jl,
                                 input logic jr, input logic br, input logic tk);
        chk("fetch_state", 32'(state), 0);
        chk("fetch_imem_req", 32'(imem_req), 1);
        imem_ack = 1'b1;
        #1;
        chk("fetch_ir_en", 32'(ir_en), 1);
        tick();
        imem_ack = 1'b0;
        chk("decode_state", 32'(state), 1);
        chk("decode_ir_en", 32'(ir_en), 0);
        load = ld; store = st; Jal = jl; Jalr = jr; branch_on = br; branch_result = tk;
        tick();
        load = 0; store = 0; Jal = 0; Jalr = 0; branch_on = 0; branch_result = 0;
        chk("exec_state", 32'(state), 2);
        chk("exec_pc_en", 32'(pc_en), 0);
    endtask

    task automatic wb_check(input string tag, input logic rwe, input logic [1:0] psel,
                            input logic [3:0] ret_before);
        chk({tag, "_wb_state"}, 32'(state), 4);
        chk({tag, "_wb_pc_en"}, 32'(pc_en), 1);
        chk({tag, "_wb_rwe"}, 32'(reg_write_en), 32'(rwe));
        chk({tag, "_wb_pc_sel"}, 32'(pc_sel), 32'(psel));
        chk({tag, "_wb_dmem_req"}, 32'(dmem_req), 0);
        chk({tag, "_wb_instret"}, 32'(instret), 32'(ret_before));
        tick();
        chk({tag, "_post_state"}, 32'(state), 0);
        chk({tag, "_post_pc_en"}, 32'(pc_en), 0);
        chk({tag, "_post_rwe"}, 32'(reg_write_en), 0);
        chk({tag, "_post_instret"}, 32'(instret), 32'(4'(ret_before + 4'd1)));
    endtask

    task automatic add_instr(input string tag, input logic [3:0] ret_before);
        fetch_to_exec(0, 0, 0, 0, 0, 0);
        tick();
        wb_check(tag, 1'b1, 2'b00, ret_before);
    endtask

    initial begin
        rst = 1; imem_ack = 0; load = 0; store = 0; Jal = 0; Jalr = 0;
        branch_on = 0; branch_result = 0; illegal = 0; dmem_ack = 0;
        tick(); tick();
        rst = 0;

        // reset state
        chk("rst_state", 32'(state), 0);
        chk("rst_imem_req", 32'(imem_req), 1);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_rwe", 32'(reg_write_en), 0);
        chk("rst_pc_en", 32'(pc_en), 0);
        chk("rst_halt", 32'(halt), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_instret", 32'(instret), 0);

        // FETCH waits without ack
        tick(); tick();
        chk("fetch_wait_state", 32'(state), 0);

        // 1. ADD
        add_instr("add", 4'd0);

        // 2. load, ack on 4th MEM cycle; dmem_ack during EXEC is ignored
        fetch_to_exec(1, 0, 0, 0, 0, 0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("ld_mem_state", 32'(state), 3);
            chk("ld_dmem_req", 32'(dmem_req), 1);
            chk("ld_dmem_we", 32'(dmem_we), 0);
            if (i == 4) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        wb_check("ld", 1'b1, 2'b00, 4'd1);

        // 3. store, ack on 1st MEM cycle
        fetch_to_exec(0, 1, 0, 0, 0, 0);
        tick();
        chk("st_mem_state", 32'(state), 3);
        chk("st_dmem_req", 32'(dmem_req), 1);
        chk("st_dmem_we", 32'(dmem_we), 1);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        wb_check("st", 1'b0, 2'b00, 4'd2);

        // 4. branches and jumps
        fetch_to_exec(0, 0, 0, 0, 1, 1);
        tick();
        wb_check("br_taken", 1'b0, 2'b01, 4'd3);
        fetch_to_exec(0, 0, 0, 0, 1, 0);
        tick();
        wb_check("br_not", 1'b0, 2'b00, 4'd4);
        fetch_to_exec(0, 0, 0, 1, 0, 0);
        tick();
        wb_check("jalr", 1'b1, 2'b10, 4'd5);
        fetch_to_exec(0, 0, 1, 0, 0, 0);
        tick();
        wb_check("jal", 1'b1, 2'b01, 4'd6);

        // 5a. load timeout with no ack
        fetch_to_exec(1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= 15; i++) begin
            chk("to_mem_state", 32'(state), 3);
            chk("to_dmem_req", 32'(dmem_req), 1);
            tick();
        end
        chk("to_halt_state", 32'(state), 5);
        chk("to_halt", 32'(halt), 1);
        chk("to_bus_err", 32'(bus_err), 1);
        chk("to_dmem_req_off", 32'(dmem_req), 0);
        chk("to_imem_req_off", 32'(imem_req), 0);
        chk("to_instret", 32'(instret), 7);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("to_halt_sticky", 32'(state), 5);
        chk("to_halt_ir_en", 32'(ir_en), 0);
        rst = 1;
        tick();
        rst = 0;
        chk("to_rst_state", 32'(state), 0);
        chk("to_rst_bus_err", 32'(bus_err), 0);
        chk("to_rst_halt", 32'(halt), 0);
        chk("to_rst_instret", 32'(instret), 0);

        // 5b. ack on the 15th MEM cycle wins
        fetch_to_exec(0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 1; i <= 15; i++) begin
            chk("late_mem_state", 32'(state), 3);
            if (i == 15) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        chk("late_bus_err", 32'(bus_err), 0);
        wb_check("late", 1'b0, 2'b00, 4'd0);

        // 5c. illegal opcode
        fetch_to_exec(0, 0, 0, 0, 0, 0);
        rst = 1;
        tick();
        rst = 0;
        chk("re_rst_state", 32'(state), 0);
        chk("re_rst_instret", 32'(instret), 0);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        illegal = 1'b1;
        tick();
        illegal = 1'b0;
        chk("ill_state", 32'(state), 5);
        chk("ill_halt", 32'(halt), 1);
        chk("ill_bus_err", 32'(bus_err), 0);
        rst = 1;
        tick();
        rst = 0;

        // 5d. load and store together
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        load = 1'b1; store = 1'b1;
        tick();
        load = 1'b0; store = 1'b0;
        chk("ldst_state", 32'(state), 5);
        chk("ldst_halt", 32'(halt), 1);
        chk("ldst_bus_err", 32'(bus_err), 0);
        rst = 1;
        tick();
        rst = 0;

        // 6a. reset during 3rd MEM cycle
        add_instr("pre", 4'd0);
        add_instr("pre2", 4'd1);
        fetch_to_exec(1, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        chk("mr_mem_state", 32'(state), 3);
        chk("mr_dmem_req", 32'(dmem_req), 1);
        rst = 1;
        tick();
        rst = 0;
        chk("mr_state", 32'(state), 0);
        chk("mr_dmem_req", 32'(dmem_req), 0);
        chk("mr_instret", 32'(instret), 0);
        chk("mr_imem_req", 32'(imem_req), 1);

        // 6b. 16 ADDs wrap the 4-bit counter
        for (int i = 0; i < 16; i++) add_instr("wrap", 4'(i));
        chk("wrap_instret", 32'(instret), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench timeout");
    end

endmodule
